// File: rtl/cpu_boot_sequencer_if.sv
// Load stream (host -> sequencer) and program-memory write port (sequencer -> memory).
interface cpu_boot_sequencer_if #(
   parameter int WordSize     = 16,
   parameter int ProgAddrSize = 8
);
   logic                    load_valid;
   logic                    load_ready;
   logic [WordSize-1:0]     load_data;
   logic                    load_last;
   logic                    prog_we;
   logic [ProgAddrSize-1:0] prog_addr;
   logic [WordSize-1:0]     prog_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, prog_we, prog_addr, prog_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, prog_we, prog_addr, prog_wdata
   );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// Loads a program into memory over a valid/ready stream, releases the CPU from reset,
// counts run cycles and re-asserts reset once the PC is seen spinning in a tight loop.
module cpu_boot_sequencer #(
   parameter int WordSize        = 16,
   parameter int ProgAddrSize    = 8,
   parameter int ResetHoldCycles = 2,
   parameter int HaltCycles      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   cpu_boot_sequencer_if.slave     bus,
   output logic                    cpu_reset,
   input  logic [ProgAddrSize-1:0] progCounter,
   output logic                    running,
   output logic                    halted,
   output logic                    error,
   output logic [ProgAddrSize:0]   prog_len,
   output logic [31:0]             run_cycles
);
   localparam int HoldW = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;
   localparam int HitW  = $clog2(HaltCycles + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_HALTED, S_ERROR} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [ProgAddrSize-1:0] r_addr;
   logic [ProgAddrSize:0]   r_len;
   logic                    r_we;
   logic [ProgAddrSize-1:0] r_waddr;
   logic [WordSize-1:0]     r_wdata;
   logic [HoldW-1:0]        r_hold;
   logic [31:0]             r_run_cycles;
   logic [ProgAddrSize-1:0] r_pc_d1;
   logic [ProgAddrSize-1:0] r_pc_d2;
   logic [HitW-1:0]         r_hits;
   logic                    w_hs;
   logic                    w_hit;
   logic                    w_halt;

   // abort blocks a same-cycle handshake so nothing new is written after it
   assign w_hs   = bus.load_valid && (r_state == S_LOAD) && !abort;
   // pc_d2 only holds a RUN-era PC once two RUN cycles have passed
   assign w_hit  = (r_state == S_RUN) && (progCounter == r_pc_d2) && (r_run_cycles >= 32'd2);
   assign w_halt = w_hit && (r_hits == HitW'(HaltCycles - 1));

   always_comb begin
      w_next = r_state;
      if (abort && (r_state != S_IDLE)) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD: begin
               if (w_hs && bus.load_last)          w_next = S_HOLD;
               else if (w_hs && (r_addr == '1))    w_next = S_ERROR;
            end
            S_HOLD:   if (r_hold == HoldW'(ResetHoldCycles - 1)) w_next = S_RUN;
            S_RUN:    if (w_halt) w_next = S_HALTED;
            S_HALTED: if (start) w_next = S_LOAD;
            S_ERROR:  if (start) w_next = S_LOAD;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_addr  <= '0;
         r_len   <= '0;
      end else begin
         r_we <= w_hs;
         if (w_hs) begin
            r_waddr <= r_addr;
            r_wdata <= bus.load_data;
         end
         if ((r_state == S_IDLE) || ((w_next == S_LOAD) && (r_state != S_LOAD))) begin
            r_addr <= '0;
            r_len  <= '0;
         end else if (w_hs) begin
            r_addr <= r_addr + 1'b1;
            r_len  <= r_len + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold       <= '0;
         r_run_cycles <= '0;
         r_pc_d1      <= '0;
         r_pc_d2      <= '0;
         r_hits       <= '0;
      end else begin
         r_hold  <= (r_state == S_HOLD) ? r_hold + 1'b1 : '0;
         r_pc_d1 <= progCounter;
         r_pc_d2 <= r_pc_d1;
         r_hits  <= w_hit ? r_hits + 1'b1 : '0;
         if (r_state == S_HOLD)
            r_run_cycles <= '0;
         else if ((r_state == S_RUN) && (r_run_cycles != '1))
            r_run_cycles <= r_run_cycles + 1'b1;
      end
   end

   assign bus.load_ready = (r_state == S_LOAD);
   assign bus.prog_we    = r_we;
   assign bus.prog_addr  = r_waddr;
   assign bus.prog_wdata = r_wdata;
   assign cpu_reset      = (r_state != S_RUN);
   assign running        = (r_state == S_RUN);
   assign halted         = (r_state == S_HALTED);
   assign error          = (r_state == S_ERROR);
   assign prog_len       = r_len;
   assign run_cycles     = r_run_cycles;
endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer with a 4-word program memory (ProgAddrSize = 2).
module tb_cpu_boot_sequencer;
   localparam int WS  = 16;
   localparam int PAS = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           abort;
   logic           cpu_reset;
   logic [PAS-1:0] progCounter;
   logic           running;
   logic           halted;
   logic           error;
   logic [PAS:0]   prog_len;
   logic [31:0]    run_cycles;
   int             checks = 0;
   int             errors = 0;

   cpu_boot_sequencer_if #(.WordSize(WS), .ProgAddrSize(PAS)) bus ();

   cpu_boot_sequencer #(
      .WordSize(WS), .ProgAddrSize(PAS), .ResetHoldCycles(2), .HaltCycles(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(bus),
      .cpu_reset(cpu_reset), .progCounter(progCounter), .running(running),
      .halted(halted), .error(error), .prog_len(prog_len), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; abort = 1'b0; progCounter = '0;
      bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
      tick; tick;
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
      checks++; if ({bus.load_ready, bus.prog_we, running, halted, error} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.load_ready, bus.prog_we, running, halted, error}); end
      checks++; if ({prog_len, run_cycles} !== '0) begin errors++; $display("FAIL reset_counts len=%0d cyc=%0d exp=0", prog_len, run_cycles); end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_basic_load;
      logic [WS-1:0] words [3] = '{16'h0010, 16'h0020, 16'h0030};
      start = 1'b1; tick; start = 1'b0;
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", bus.load_ready); end
      bus.load_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.load_data = words[i];
         bus.load_last = (i == 2);
         tick;
         checks++; if ({bus.prog_we, bus.prog_addr, bus.prog_wdata} !== {1'b1, i[PAS-1:0], words[i]}) begin errors++; $display("FAIL basic_write%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, bus.prog_we, bus.prog_addr, bus.prog_wdata, i, words[i]); end
      end
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
      checks++; if (prog_len !== 3'd3) begin errors++; $display("FAIL basic_len got=%0d exp=3", prog_len); end
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got=%b exp=0", bus.load_ready); end
      tick;
      checks++; if ({cpu_reset, bus.prog_we} !== 2'b10) begin errors++; $display("FAIL basic_hold2 got rst/we=%b exp=10", {cpu_reset, bus.prog_we}); end
      tick;
      checks++; if ({cpu_reset, running} !== 2'b01) begin errors++; $display("FAIL basic_release got rst/run=%b exp=01", {cpu_reset, running}); end
   endtask

   task automatic test_abort_run;
      abort = 1'b1; start = 1'b1; tick;
      abort = 1'b0; start = 1'b0;
      checks++; if ({cpu_reset, running, bus.load_ready} !== 3'b100) begin errors++; $display("FAIL abort_run got rst/run/rdy=%b exp=100", {cpu_reset, running, bus.load_ready}); end
      tick;
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL abort_run_idle got rdy=%b exp=0", bus.load_ready); end
   endtask

   task automatic test_gaps;
      logic [5:0] pat = 6'b101001;
      int n = 0;
      start = 1'b1; tick; start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.load_valid = pat[i];
         bus.load_data  = WS'(16'h0100 + i);
         bus.load_last  = (i == 5);
         tick;
         checks++; if (bus.prog_we !== pat[i]) begin errors++; $display("FAIL gaps_we%0d got=%b exp=%b", i, bus.prog_we, pat[i]); end
         if (pat[i]) begin
            checks++; if ({bus.prog_addr, bus.prog_wdata} !== {n[PAS-1:0], WS'(16'h0100 + i)}) begin errors++; $display("FAIL gaps_write%0d got a=%0d d=%h exp a=%0d d=%h", i, bus.prog_addr, bus.prog_wdata, n, 16'h0100 + i); end
            n++;
         end
      end
      bus.load_valid = 1'b0; bus.load_last = 1'b0;
      checks++; if (prog_len !== 3'd3) begin errors++; $display("FAIL gaps_len got=%0d exp=3", prog_len); end
      tick; tick;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL gaps_release got run=%b exp=1", running); end
   endtask

   task automatic test_halt;
      logic [PAS-1:0] seq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
      for (int k = 0; k < 8; k++) begin
         progCounter = seq[k];
         tick;
         if (k == 6) begin
            checks++; if ({running, halted} !== 2'b10) begin errors++; $display("FAIL halt_early got run/halt=%b exp=10", {running, halted}); end
         end
      end
      checks++; if ({halted, cpu_reset, running} !== 3'b110) begin errors++; $display("FAIL halt_flags got halt/rst/run=%b exp=110", {halted, cpu_reset, running}); end
      checks++; if (run_cycles !== 32'd8) begin errors++; $display("FAIL halt_cycles got=%0d exp=8", run_cycles); end
      progCounter = seq[8];
      tick;
      checks++; if ({halted, run_cycles} !== {1'b1, 32'd8}) begin errors++; $display("FAIL halt_frozen got halt=%b cyc=%0d exp halt=1 cyc=8", halted, run_cycles); end
   endtask

   task automatic test_overflow;
      start = 1'b1; tick; start = 1'b0;
      checks++; if ({halted, bus.load_ready, prog_len} !== {2'b01, 3'd0}) begin errors++; $display("FAIL ovf_restart got halt=%b rdy=%b len=%0d exp halt=0 rdy=1 len=0", halted, bus.load_ready, prog_len); end
      bus.load_valid = 1'b1; bus.load_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.load_data = WS'(16'h00A0 + i);
         tick;
         checks++; if ({bus.prog_we, bus.prog_addr, bus.prog_wdata} !== {1'b1, i[PAS-1:0], WS'(16'h00A0 + i)}) begin errors++; $display("FAIL ovf_write%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, bus.prog_we, bus.prog_addr, bus.prog_wdata, i, 16'h00A0 + i); end
      end
      checks++; if ({error, bus.load_ready} !== 2'b10) begin errors++; $display("FAIL ovf_error got err/rdy=%b exp=10", {error, bus.load_ready}); end
      bus.load_data = 16'h00A4;
      tick;
      checks++; if ({bus.prog_we, prog_len, error} !== {1'b0, 3'd4, 1'b1}) begin errors++; $display("FAIL ovf_5th got we=%b len=%0d err=%b exp we=0 len=4 err=1", bus.prog_we, prog_len, error); end
      bus.load_valid = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      checks++; if ({error, bus.load_ready, prog_len} !== {2'b01, 3'd0}) begin errors++; $display("FAIL ovf_clear got err=%b rdy=%b len=%0d exp err=0 rdy=1 len=0", error, bus.load_ready, prog_len); end
   endtask

   task automatic test_async_reset;
      bus.load_valid = 1'b1; bus.load_data = 16'h0055; tick;
      bus.load_data = 16'h0066; tick;
      checks++; if ({bus.prog_we, prog_len} !== {1'b1, 3'd2}) begin errors++; $display("FAIL areset_pre got we=%b len=%0d exp we=1 len=2", bus.prog_we, prog_len); end
      #1 reset = 1'b1;
      #1;
      checks++; if ({bus.prog_we, bus.load_ready, prog_len, cpu_reset} !== {2'b00, 3'd0, 1'b1}) begin errors++; $display("FAIL areset_now got we=%b rdy=%b len=%0d rst=%b exp we=0 rdy=0 len=0 rst=1", bus.prog_we, bus.load_ready, prog_len, cpu_reset); end
      bus.load_valid = 1'b0;
      #1 reset = 1'b0;
      tick;
      checks++; if ({bus.load_ready, bus.prog_we, error} !== 3'b000) begin errors++; $display("FAIL areset_idle got rdy/we/err=%b exp=000", {bus.load_ready, bus.prog_we, error}); end
   endtask

   task automatic test_abort_load;
      start = 1'b1; tick; start = 1'b0;
      bus.load_valid = 1'b1; bus.load_data = 16'h0077; tick;
      checks++; if ({bus.prog_we, bus.prog_addr, bus.prog_wdata} !== {1'b1, 2'd0, 16'h0077}) begin errors++; $display("FAIL abortld_write got we=%b a=%0d d=%h exp we=1 a=0 d=0077", bus.prog_we, bus.prog_addr, bus.prog_wdata); end
      abort = 1'b1; bus.load_data = 16'h0088; tick;
      abort = 1'b0; bus.load_valid = 1'b0;
      checks++; if ({bus.prog_we, bus.load_ready, prog_len} !== {2'b00, 3'd1}) begin errors++; $display("FAIL abortld_stop got we=%b rdy=%b len=%0d exp we=0 rdy=0 len=1", bus.prog_we, bus.load_ready, prog_len); end
      tick;
      checks++; if ({bus.load_ready, prog_len} !== {1'b0, 3'd0}) begin errors++; $display("FAIL abortld_idle got rdy=%b len=%0d exp rdy=0 len=0", bus.load_ready, prog_len); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_basic_load;
      test_abort_run;
      test_gaps;
      test_halt;
      test_overflow;
      test_async_reset;
      test_abort_load;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Controller that owns the `cpu` core's reset line and the program-memory write port. After `start`, it loads a program word-by-word through a valid/ready stream into program memory, then releases the CPU from reset. It monitors `progCounter` while the CPU runs, reports how many cycles it ran, and re-asserts CPU reset when the program halts, on abort, or after a load overflow. It sits between the host/loader interface, program memory, and the `cpu` instance.

## Interface

Parameters:
- `WordSize`, default `DefaultWordSize`: program word width.
- `ProgAddrSize`, default `DefaultProgAddrSize`: program address width; capacity is 2^ProgAddrSize words.
- `ResetHoldCycles`, default 2, minimum 1: number of cycles `cpu_reset` stays high after a load before the CPU is released.
- `HaltCycles`, default 4, minimum 1: number of consecutive loop-detect cycles required to declare a halt.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a load; sampled only in IDLE, HALTED and ERROR.
- `abort`  in  1  forces a return to IDLE from any state except IDLE.
- `load_valid`  in  1  a load word is present.
- `load_ready`  out  1  the sequencer accepts a word this cycle.
- `load_data`  in  WordSize  program word.
- `load_last`  in  1  marks the final word; qualified by the handshake.
- `prog_we`  out  1  program memory write strobe (registered).
- `prog_addr`  out  ProgAddrSize  program memory write address (registered).
- `prog_wdata`  out  WordSize  program memory write data (registered).
- `cpu_reset`  out  1  drives the `reset` input of `cpu`.
- `progCounter`  in  ProgAddrSize  PC from `cpu`.
- `running`  out  1  high while in RUN.
- `halted`  out  1  high while in HALTED.
- `error`  out  1  high while in ERROR.
- `prog_len`  out  ProgAddrSize+1  number of words written by the last load.
- `run_cycles`  out  32  number of RUN cycles since the last release; saturates at 2^32-1.

## Operation

- **States:** IDLE, LOAD, HOLD, RUN, HALTED, ERROR. `cpu_reset` = 1 in every state except RUN.
- **Reset values:** state = IDLE, `cpu_reset` = 1, and all other outputs and counters = 0.
- **IDLE:**
  - `start` → LOAD.
  - The write address counter and `prog_len` clear to 0.
- **LOAD:**
  - `load_ready` = 1.
  - A handshake is `load_valid & load_ready`. On a handshake, the next cycle drives `prog_we` = 1, `prog_addr` = counter, and `prog_wdata` = `load_data`.
  - The counter and `prog_len` increment on each handshake.
  - A handshake with `load_last` = 1 → HOLD.
  - A handshake with `load_last` = 0 at address 2^ProgAddrSize-1 → ERROR. That word is still written.
  - No handshake means no change.
- **HOLD:**
  - `load_ready` = 0.
  - A hold counter runs for ResetHoldCycles cycles, then the state moves to RUN.
  - `run_cycles` clears on entry to HOLD.
- **RUN:**
  - `cpu_reset` = 0 and `running` = 1.
  - `run_cycles` increments every RUN cycle.
  - Loop detection: the block registers `progCounter` delayed by 1 and by 2 cycles (`pc_d1`, `pc_d2`). A cycle is a loop hit when `progCounter == pc_d2` and at least 2 RUN cycles have elapsed. A hit covers both a one-instruction self-jump and the two-instruction `@L; 0;JMP` idiom.
  - A hit counter increments on each hit and clears on any non-hit.
  - When the hit counter reaches HaltCycles → HALTED.
- **HALTED / ERROR:**
  - The status flag (`halted` or `error`) is held.
  - `prog_len` and `run_cycles` are frozen.
  - `start` → LOAD, which clears the flag, the address counter, and `prog_len`.
- **abort:** takes priority over every other transition in the same cycle and moves to IDLE.
- **start:** ignored in LOAD, HOLD and RUN.

## Timing

- State, flags, `load_ready` and `cpu_reset` are Moore outputs of the registered state. They change one cycle after the triggering event.
- Write latency: `prog_we` pulses exactly 1 cycle after its handshake and lasts 1 cycle per word. Back-to-back handshakes produce back-to-back writes.
- Last word: the state is HOLD in the cycle after the handshake, and the final write occurs during the first HOLD cycle.
- `cpu_reset` falls exactly ResetHoldCycles+1 cycles after the `load_last` handshake.
- Halt: `halted` rises 1 cycle after the HaltCycles-th consecutive hit, and `cpu_reset` rises in the same cycle.
- Asynchronous `reset` mid-load or mid-run:
  - All outputs go to their reset values immediately.
  - Any pending `prog_we` is dropped.
  - `cpu_reset` goes to 1 without waiting for a clock edge.
- `abort` in LOAD: a write already registered for this cycle still completes, and no further handshakes are accepted.

## Test plan

- **Basic load and release:** `start`, then words 0x0010, 0x0020, 0x0030 with `last` on the third → `prog_we` pulses at addresses 0, 1, 2 with that data; `prog_len` = 3; `cpu_reset` falls 3 cycles after the third handshake.
- **Backpressure and gaps:** toggle `load_valid` 1,0,0,1,0,1 with `last` on the third valid → exactly 3 writes at addresses 0–2; the counter never advances on idle cycles.
- **Overflow:** ProgAddrSize = 2, send 5 words with no `last` → 4 writes (addresses 0–3); `error` = 1 after the 4th handshake; the 5th word is not accepted (`load_ready` = 0). A following `start` clears `error`.
- **Halt detection:** in RUN, drive PC 0, 1, 2, 3, 4, 3, 4, 3, 4, … with HaltCycles = 4 → `halted` = 1 and `cpu_reset` = 1 exactly one cycle after the 4th hit; `run_cycles` is frozen at its value from that cycle.
- **Abort in RUN:** assert `abort` together with `start` → next cycle IDLE, `cpu_reset` = 1, `running` = 0; `start` is ignored.
- **Asynchronous reset mid-LOAD:** pulse `reset` between clock edges after 2 handshakes → `prog_we` = 0, `load_ready` = 0, `prog_len` = 0, `cpu_reset` = 1 immediately; the state is IDLE after release.
